// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / hazard control block.
// Covers the forward-select encoding, the stall FSM states and the default address width.
package forwarding_pkg;

   localparam int NB_ADDR_DEF = 5;
   localparam int FWD_SEL_RF  = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } fsm_state_t;

   // Stage k is encoded as k+1 so that 0 can mean "read the register file".
   function automatic int fwd_sel_enc(input int stage);
      return stage + 1;
   endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Bundle of the pipeline-facing signals of the forwarding / hazard unit.
// The pipeline (master) drives the operand and stage info; the unit (slave) returns the controls.
interface forwarding_hazard_unit_if
   import forwarding_pkg::*;
#(
   parameter int NB_ADDR = NB_ADDR_DEF,
   parameter int NUM_SRC = 2,
   parameter int NUM_FWD = 2,
   parameter int NB_CNT  = 32
);
   localparam int NB_SEL = $clog2(NUM_FWD + 1);

   logic [NUM_SRC*NB_ADDR-1:0] ex_src_addr;
   logic [NUM_SRC-1:0]         ex_src_used;
   logic [NUM_FWD*NB_ADDR-1:0] fwd_dst_addr;
   logic [NUM_FWD-1:0]         fwd_reg_write;
   logic [NUM_SRC*NB_ADDR-1:0] id_src_addr;
   logic [NUM_SRC-1:0]         id_src_used;
   logic                       ex_mem_read;
   logic [NB_ADDR-1:0]         ex_dst_addr;
   logic                       flush;
   logic                       hold;
   logic [NUM_SRC*NB_SEL-1:0]  fwd_sel;
   logic                       stall;
   logic                       bubble;
   logic [NB_CNT-1:0]          stall_count;

   modport master (
      output ex_src_addr, ex_src_used, fwd_dst_addr, fwd_reg_write,
             id_src_addr, id_src_used, ex_mem_read, ex_dst_addr, flush, hold,
      input  fwd_sel, stall, bubble, stall_count
   );

   modport slave (
      input  ex_src_addr, ex_src_used, fwd_dst_addr, fwd_reg_write,
             id_src_addr, id_src_used, ex_mem_read, ex_dst_addr, flush, hold,
      output fwd_sel, stall, bubble, stall_count
   );

endinterface

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// Forward-source priority encoder for one ALU operand against all writer stages.
// The youngest (lowest index) matching stage wins; $zero and unused operands read the register file.
module fwd_select
   import forwarding_pkg::*;
#(
   parameter int NB_ADDR = NB_ADDR_DEF,
   parameter int NUM_FWD = 2,
   parameter int NB_SEL  = $clog2(NUM_FWD + 1)
) (
   input  logic [NB_ADDR-1:0]         src_addr,
   input  logic                       src_used,
   input  logic [NUM_FWD*NB_ADDR-1:0] fwd_dst_addr,
   input  logic [NUM_FWD-1:0]         fwd_reg_write,
   output logic [NB_SEL-1:0]          sel
);

   logic [NUM_FWD-1:0] match;

   generate
      for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
         assign match[gi] = fwd_reg_write[gi] &&
                            (fwd_dst_addr[gi*NB_ADDR +: NB_ADDR] == src_addr);
      end
   endgenerate

   // Scan oldest to youngest so the last hit written is the youngest one.
   always_comb begin
      sel = NB_SEL'(FWD_SEL_RF);
      if (src_used && (src_addr != '0)) begin
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (match[k]) begin
               sel = NB_SEL'(fwd_sel_enc(k));
            end
         end
      end
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// EX-stage operand forwarding plus load-use stall sequencing, flush/hold override
// and a saturating count of stall cycles.
module forwarding_hazard_unit
   import forwarding_pkg::*;
#(
   parameter int NB_ADDR  = NB_ADDR_DEF,
   parameter int NUM_SRC  = 2,
   parameter int NUM_FWD  = 2,
   parameter int LOAD_LAT = 1,
   parameter int NB_CNT   = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   forwarding_hazard_unit_if.slave  bus
);

   localparam int NB_SEL = $clog2(NUM_FWD + 1);
   localparam int CNT_W  = $clog2(LOAD_LAT + 1);

   logic [NUM_SRC*NB_SEL-1:0] sel_raw;
   logic [NUM_SRC-1:0]        id_match;
   logic                      haz;

   fsm_state_t         state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [NB_CNT-1:0]  stall_count_reg;
   logic               stall_int, bubble_int;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         fwd_select #(
            .NB_ADDR (NB_ADDR),
            .NUM_FWD (NUM_FWD),
            .NB_SEL  (NB_SEL)
         ) u_fwd_select (
            .src_addr      (bus.ex_src_addr[gi*NB_ADDR +: NB_ADDR]),
            .src_used      (bus.ex_src_used[gi]),
            .fwd_dst_addr  (bus.fwd_dst_addr),
            .fwd_reg_write (bus.fwd_reg_write),
            .sel           (sel_raw[gi*NB_SEL +: NB_SEL])
         );

         assign id_match[gi] = bus.id_src_used[gi] &&
                               (bus.id_src_addr[gi*NB_ADDR +: NB_ADDR] == bus.ex_dst_addr);
      end
   endgenerate

   assign haz = bus.ex_mem_read && (bus.ex_dst_addr != '0) && (|id_match);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      stall_int  = 1'b0;
      bubble_int = 1'b0;
      if (bus.flush) begin
         bubble_int = 1'b1;
         state_next = IDLE;
         cnt_next   = '0;
      end else if (bus.hold) begin
         stall_int  = 1'b1;
         bubble_int = (state_reg == STALL);
      end else begin
         case (state_reg)
            IDLE: begin
               if (haz) begin
                  stall_int  = 1'b1;
                  bubble_int = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_next = STALL;
                     cnt_next   = CNT_W'(LOAD_LAT - 1);
                  end
               end
            end
            STALL: begin
               stall_int  = 1'b1;
               bubble_int = 1'b1;
               cnt_next   = cnt_reg - CNT_W'(1);
               if (cnt_reg == CNT_W'(1)) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         stall_count_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         // Held cycles are not counted; the count sticks at all-ones.
         if (stall_int && !bus.hold && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + NB_CNT'(1);
         end
      end
   end

   assign bus.fwd_sel     = i_rst_n ? sel_raw : '0;
   assign bus.stall       = i_rst_n && stall_int;
   assign bus.bubble      = i_rst_n && bubble_int;
   assign bus.stall_count = stall_count_reg;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Drives one stimulus stream into a LOAD_LAT=1 (4-bit counter) and a LOAD_LAT=3 unit,
// comparing both against a remaining-stall-cycles reference model.
module tb_forwarding_hazard_unit;
   import forwarding_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [9:0] ex_src_addr;
   logic [1:0] ex_src_used;
   logic [9:0] fwd_dst_addr;
   logic [1:0] fwd_reg_write;
   logic [9:0] id_src_addr;
   logic [1:0] id_src_used;
   logic       ex_mem_read;
   logic [4:0] ex_dst_addr;
   logic       flush;
   logic       hold;

   forwarding_hazard_unit_if #(.NB_ADDR(5), .NUM_SRC(2), .NUM_FWD(2), .NB_CNT(4))  if1 ();
   forwarding_hazard_unit_if #(.NB_ADDR(5), .NUM_SRC(2), .NUM_FWD(2), .NB_CNT(32)) if3 ();

   assign if1.ex_src_addr   = ex_src_addr;    assign if3.ex_src_addr   = ex_src_addr;
   assign if1.ex_src_used   = ex_src_used;    assign if3.ex_src_used   = ex_src_used;
   assign if1.fwd_dst_addr  = fwd_dst_addr;   assign if3.fwd_dst_addr  = fwd_dst_addr;
   assign if1.fwd_reg_write = fwd_reg_write;  assign if3.fwd_reg_write = fwd_reg_write;
   assign if1.id_src_addr   = id_src_addr;    assign if3.id_src_addr   = id_src_addr;
   assign if1.id_src_used   = id_src_used;    assign if3.id_src_used   = id_src_used;
   assign if1.ex_mem_read   = ex_mem_read;    assign if3.ex_mem_read   = ex_mem_read;
   assign if1.ex_dst_addr   = ex_dst_addr;    assign if3.ex_dst_addr   = ex_dst_addr;
   assign if1.flush         = flush;          assign if3.flush         = flush;
   assign if1.hold          = hold;           assign if3.hold          = hold;

   forwarding_hazard_unit #(.NB_ADDR(5), .NUM_SRC(2), .NUM_FWD(2), .LOAD_LAT(1), .NB_CNT(4))
      dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
   forwarding_hazard_unit #(.NB_ADDR(5), .NUM_SRC(2), .NUM_FWD(2), .LOAD_LAT(3), .NB_CNT(32))
      dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));

   int vectors    = 0;
   int miscompares = 0;

   // Reference state: stall cycles still owed and the stall total, per unit.
   int      lat  [2] = '{1, 3};
   longint  cmax [2] = '{15, 64'h0000_0000_FFFF_FFFF};
   int      rem  [2];
   longint  cnt  [2];
   bit      known = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] model_fwd();
      logic [3:0] r = '0;
      for (int s = 0; s < 2; s++) begin
         int sel = 0;
         logic [4:0] src = ex_src_addr[s*5 +: 5];
         if (ex_src_used[s] && src != 0) begin
            for (int k = 0; k < 2; k++) begin
               if (sel == 0 && fwd_reg_write[k] && fwd_dst_addr[k*5 +: 5] == src) sel = k + 1;
            end
         end
         r[s*2 +: 2] = 2'(sel);
      end
      return rst_n ? r : 4'd0;
   endfunction

   function automatic bit model_haz();
      bit any = 1'b0;
      for (int s = 0; s < 2; s++) begin
         if (id_src_used[s] && id_src_addr[s*5 +: 5] == ex_dst_addr) any = 1'b1;
      end
      return ex_mem_read && ex_dst_addr != 0 && any;
   endfunction

   // One clock: check mid-cycle (falling edge) against the model, then advance over the rising edge.
   task automatic cycle();
      logic [3:0] ef;
      bit h;
      bit es [2];
      bit eb [2];
      int nrem [2];
      longint ncnt [2];
      logic [3:0] of;
      logic os, ob;
      logic [63:0] oc;
      #4;
      ef = model_fwd();
      h  = model_haz();
      for (int d = 0; d < 2; d++) begin
         nrem[d] = rem[d];
         ncnt[d] = cnt[d];
         if (!rst_n) begin
            es[d] = 0; eb[d] = 0; nrem[d] = 0; ncnt[d] = 0;
         end else if (flush) begin
            es[d] = 0; eb[d] = 1; nrem[d] = 0;
         end else if (hold) begin
            es[d] = 1; eb[d] = (rem[d] > 0);
         end else if (rem[d] > 0 || h) begin
            es[d] = 1; eb[d] = 1;
            nrem[d] = (rem[d] > 0) ? rem[d] - 1 : lat[d] - 1;
            if (cnt[d] < cmax[d]) ncnt[d] = cnt[d] + 1;
         end else begin
            es[d] = 0; eb[d] = 0;
         end
         of = (d == 0) ? if1.fwd_sel : if3.fwd_sel;
         os = (d == 0) ? if1.stall   : if3.stall;
         ob = (d == 0) ? if1.bubble  : if3.bubble;
         oc = (d == 0) ? 64'(if1.stall_count) : 64'(if3.stall_count);
         check($sformatf("fwd_sel[u%0d]", d), 64'(of), 64'(ef));
         check($sformatf("stall[u%0d]", d), 64'(os), 64'(es[d]));
         check($sformatf("bubble[u%0d]", d), 64'(ob), 64'(eb[d]));
         if (known) check($sformatf("stall_count[u%0d]", d), oc, 64'(cnt[d]));
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         rem[d] = nrem[d];
         cnt[d] = ncnt[d];
      end
      if (!rst_n) known = 1'b1;
      #1;
   endtask

   task automatic clear_inputs();
      ex_src_addr = '0; ex_src_used = '0; fwd_dst_addr = '0; fwd_reg_write = '0;
      id_src_addr = '0; id_src_used = '0; ex_mem_read = 1'b0; ex_dst_addr = '0;
      flush = 1'b0; hold = 1'b0;
   endtask

   task automatic set_load_use();
      ex_mem_read = 1'b1; ex_dst_addr = 5'd5;
      id_src_addr = {5'd5, 5'd0}; id_src_used = 2'b10;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      @(posedge clk);
      #1;

      // Reset with a live hazard: nothing may stall.
      set_load_use();
      cycle(); cycle();
      rst_n = 1'b1;
      clear_inputs();
      cycle();
      check("reset_count_u1", 64'(if1.stall_count), 64'd0);
      check("reset_count_u3", 64'(if3.stall_count), 64'd0);

      // Forwarding priority.
      ex_src_addr = {5'd0, 5'd3}; ex_src_used = 2'b01;
      fwd_dst_addr = {5'd3, 5'd3}; fwd_reg_write = 2'b11;
      cycle();
      check("prio_youngest", 64'(if1.fwd_sel[1:0]), 64'd1);
      fwd_reg_write = 2'b10;
      cycle();
      check("prio_older", 64'(if1.fwd_sel[1:0]), 64'd2);
      ex_src_addr = '0; fwd_dst_addr = '0; fwd_reg_write = 2'b11;
      cycle();
      check("zero_reg", 64'(if1.fwd_sel[1:0]), 64'd0);
      clear_inputs();

      // Load-use stall.
      set_load_use();
      cycle();
      clear_inputs();
      repeat (4) cycle();
      check("loaduse_count_u1", 64'(if1.stall_count), 64'd1);
      check("loaduse_count_u3", 64'(if3.stall_count), 64'd3);

      // Flush in the second stall cycle.
      set_load_use();
      cycle();
      clear_inputs();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      repeat (2) cycle();
      check("flush_count_u1", 64'(if1.stall_count), 64'd2);
      check("flush_count_u3", 64'(if3.stall_count), 64'd4);

      // Debug hold during a stall.
      set_load_use();
      cycle();
      clear_inputs();
      hold = 1'b1;
      repeat (4) cycle();
      hold = 1'b0;
      repeat (3) cycle();
      check("hold_count_u1", 64'(if1.stall_count), 64'd3);
      check("hold_count_u3", 64'(if3.stall_count), 64'd7);

      // Reset in the middle of a stall, hazard still present.
      set_load_use();
      cycle();
      rst_n = 1'b0;
      cycle(); cycle();
      rst_n = 1'b1;
      clear_inputs();
      repeat (2) cycle();
      check("rst_mid_count_u3", 64'(if3.stall_count), 64'd0);

      // Continuous hazard saturates the short counter.
      set_load_use();
      repeat (20) cycle();
      clear_inputs();
      cycle();
      check("saturate_u1", 64'(if1.stall_count), 64'd15);

      // Randomised traffic over a small register range so matches are frequent.
      repeat (300) begin
         rst_n = ($urandom_range(0, 49) != 0);
         flush = ($urandom_range(0, 11) == 0);
         hold  = ($urandom_range(0, 7) == 0);
         for (int s = 0; s < 2; s++) begin
            ex_src_addr[s*5 +: 5] = 5'($urandom_range(0, 3));
            id_src_addr[s*5 +: 5] = 5'($urandom_range(0, 3));
            fwd_dst_addr[s*5 +: 5] = 5'($urandom_range(0, 3));
         end
         ex_src_used   = 2'($urandom);
         id_src_used   = 2'($urandom);
         fwd_reg_write = 2'($urandom);
         ex_mem_read   = ($urandom_range(0, 2) == 0);
         ex_dst_addr   = 5'($urandom_range(0, 3));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
